// File: rtl/wb_arbiter_if.sv
// Bundle of issue, ALU, LSU, source-query and register-file write-port signals
// between execute/LSU/decode and the writeback arbiter.
interface wb_arbiter_if #(
  parameter int WIDTH = 32
);
  logic             issue_valid;
  logic [4:0]       issue_rd;
  logic             issue_ready;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [WIDTH-1:0] alu_data;
  logic             lsu_valid;
  logic [4:0]       lsu_rd;
  logic [WIDTH-1:0] lsu_data;
  logic             lsu_ready;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             rs1_busy;
  logic             rs2_busy;
  logic [4:0]       rd;
  logic [WIDTH-1:0] rd_data;
  logic             rd_we;

  modport master (
    output issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    input  issue_ready, lsu_ready, rs1_busy, rs2_busy, rd, rd_data, rd_we
  );

  modport slave (
    input  issue_valid, issue_rd, alu_valid, alu_rd, alu_data,
           lsu_valid, lsu_rd, lsu_data, rs1, rs2,
    output issue_ready, lsu_ready, rs1_busy, rs2_busy, rd, rd_data, rd_we
  );
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges ALU and LSU results onto one register-file write
// port and keeps a scoreboard of destinations awaiting long-latency results.
module wb_arbiter #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  wb_arbiter_if.slave bus
);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]      pending_q, pending_d;
  logic [CW-1:0]    outst_q, outst_d;
  logic [CW-1:0]    count_q, count_d;
  logic [PW-1:0]    wptr_q, wptr_d;
  logic [PW-1:0]    rptr_q, rptr_d;
  logic [4:0]       fifo_rd_q   [DEPTH];
  logic [WIDTH-1:0] fifo_data_q [DEPTH];

  logic [4:0]       rd_q;
  logic [WIDTH-1:0] rd_data_q;
  logic             rd_we_q;
  logic             wb_lsu_q;

  logic             issue_ready_s;
  logic             lsu_ready_s;
  logic             push_s;
  logic             pop_s;
  logic             set_s;
  logic             clr_s;
  logic             sel_valid_s;
  logic             sel_lsu_s;
  logic [4:0]       sel_rd_s;
  logic [WIDTH-1:0] sel_data_s;

  assign issue_ready_s = (outst_q < CW'(DEPTH)) && !pending_q[bus.issue_rd];
  assign lsu_ready_s   = (count_q < CW'(DEPTH));
  assign push_s        = bus.lsu_valid && lsu_ready_s;
  assign pop_s         = !bus.alu_valid && (count_q != {CW{1'b0}});
  assign set_s         = bus.issue_valid && issue_ready_s && (bus.issue_rd != 5'd0);
  // A popped LSU write clears its reservation at the end of its rd_we cycle.
  assign clr_s         = rd_we_q && wb_lsu_q;

  assign bus.issue_ready = issue_ready_s;
  assign bus.lsu_ready   = lsu_ready_s;
  assign bus.rs1_busy    = pending_q[bus.rs1] && (bus.rs1 != 5'd0);
  assign bus.rs2_busy    = pending_q[bus.rs2] && (bus.rs2 != 5'd0);
  assign bus.rd          = rd_q;
  assign bus.rd_data     = rd_data_q;
  assign bus.rd_we       = rd_we_q;

  // Source selection: ALU has priority, FIFO head otherwise.
  always_comb begin
    sel_valid_s = 1'b0;
    sel_lsu_s   = 1'b0;
    sel_rd_s    = rd_q;
    sel_data_s  = rd_data_q;
    if (bus.alu_valid) begin
      sel_valid_s = 1'b1;
      sel_rd_s    = bus.alu_rd;
      sel_data_s  = bus.alu_data;
    end else if (pop_s) begin
      sel_valid_s = 1'b1;
      sel_lsu_s   = 1'b1;
      sel_rd_s    = fifo_rd_q[rptr_q];
      sel_data_s  = fifo_data_q[rptr_q];
    end else begin
      sel_valid_s = 1'b0;
    end
  end

  // Scoreboard and FIFO pointer next state; a same-index set overrides a clear.
  always_comb begin
    pending_d = pending_q;
    if (clr_s) begin
      pending_d[rd_q] = 1'b0;
    end else begin
      pending_d = pending_q;
    end
    if (set_s) begin
      pending_d[bus.issue_rd] = 1'b1;
    end else begin
      pending_d[0] = pending_d[0];
    end

    case ({set_s, clr_s})
      2'b10:   outst_d = outst_q + CW'(1);
      2'b01:   outst_d = outst_q - CW'(1);
      default: outst_d = outst_q;
    endcase

    count_d = count_q + CW'(push_s) - CW'(pop_s);

    wptr_d = wptr_q;
    if (push_s) begin
      wptr_d = (wptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : wptr_q + PW'(1);
    end else begin
      wptr_d = wptr_q;
    end
    rptr_d = rptr_q;
    if (pop_s) begin
      rptr_d = (rptr_q == PW'(DEPTH - 1)) ? {PW{1'b0}} : rptr_q + PW'(1);
    end else begin
      rptr_d = rptr_q;
    end
  end

  // State registers, FIFO storage and the registered write port.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= 32'd0;
      outst_q   <= {CW{1'b0}};
      count_q   <= {CW{1'b0}};
      wptr_q    <= {PW{1'b0}};
      rptr_q    <= {PW{1'b0}};
      rd_q      <= 5'd0;
      rd_data_q <= {WIDTH{1'b0}};
      rd_we_q   <= 1'b0;
      wb_lsu_q  <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        fifo_rd_q[i]   <= 5'd0;
        fifo_data_q[i] <= {WIDTH{1'b0}};
      end
    end else begin
      pending_q <= pending_d;
      outst_q   <= outst_d;
      count_q   <= count_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      if (push_s) begin
        fifo_rd_q[wptr_q]   <= bus.lsu_rd;
        fifo_data_q[wptr_q] <= bus.lsu_data;
      end
      if (sel_valid_s) begin
        rd_q      <= sel_rd_s;
        rd_data_q <= sel_data_s;
      end
      rd_we_q  <= sel_valid_s && (sel_rd_s != 5'd0);
      wb_lsu_q <= sel_lsu_s && (sel_rd_s != 5'd0);
    end
  end
endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter with hand-computed expectations.
module tb_wb_arbiter;
  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fail;

  wb_arbiter_if #(.WIDTH(32)) bus ();

  wb_arbiter #(.WIDTH(32), .DEPTH(2)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
    bus.issue_valid = 1'b0;
    bus.alu_valid   = 1'b0;
    bus.lsu_valid   = 1'b0;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk_wr(input string tag, input logic [4:0] rd, input logic [31:0] data);
    chk({tag, "_we"}, 64'(bus.rd_we), 64'd1);
    chk({tag, "_rd"}, 64'(bus.rd), 64'(rd));
    chk({tag, "_data"}, 64'(bus.rd_data), 64'(data));
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0;
    bus.issue_valid = 1'b0; bus.issue_rd = 5'd0;
    bus.alu_valid = 1'b0; bus.alu_rd = 5'd0; bus.alu_data = 32'd0;
    bus.lsu_valid = 1'b0; bus.lsu_rd = 5'd0; bus.lsu_data = 32'd0;
    bus.rs1 = 5'd0; bus.rs2 = 5'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // reset state
    bus.rs1 = 5'd7; bus.rs2 = 5'd9; bus.issue_rd = 5'd7;
    #1;
    chk("rst_we", 64'(bus.rd_we), 64'd0);
    chk("rst_rd", 64'(bus.rd), 64'd0);
    chk("rst_data", 64'(bus.rd_data), 64'd0);
    chk("rst_issue_ready", 64'(bus.issue_ready), 64'd1);
    chk("rst_lsu_ready", 64'(bus.lsu_ready), 64'd1);
    chk("rst_busy1", 64'(bus.rs1_busy), 64'd0);
    chk("rst_busy2", 64'(bus.rs2_busy), 64'd0);

    // ALU path, nonzero and zero destination
    next_cyc();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
    next_cyc();
    mid(); chk_wr("alu", 5'd5, 32'hDEADBEEF);
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h00000055;
    next_cyc();
    mid();
    chk("alu_r0_we", 64'(bus.rd_we), 64'd0);
    chk("alu_r0_data", 64'(bus.rd_data), 64'h55);

    // LSU path with busy tracking (cycle 0 = issue)
    next_cyc();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd7; bus.rs1 = 5'd7;
    mid();
    chk("lsu_c0_ready", 64'(bus.issue_ready), 64'd1);
    chk("lsu_c0_busy", 64'(bus.rs1_busy), 64'd0);
    next_cyc(); mid(); chk("lsu_c1_busy", 64'(bus.rs1_busy), 64'd1);
    next_cyc(); mid(); chk("lsu_c2_busy", 64'(bus.rs1_busy), 64'd1);
    next_cyc();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd7; bus.lsu_data = 32'h00001234;
    mid(); chk("lsu_c3_lready", 64'(bus.lsu_ready), 64'd1);
    next_cyc(); mid();
    chk("lsu_c4_we", 64'(bus.rd_we), 64'd0);
    chk("lsu_c4_busy", 64'(bus.rs1_busy), 64'd1);
    next_cyc(); mid();
    chk_wr("lsu_c5", 5'd7, 32'h00001234);
    chk("lsu_c5_busy", 64'(bus.rs1_busy), 64'd1);
    next_cyc(); mid();
    chk("lsu_c6_busy", 64'(bus.rs1_busy), 64'd0);
    chk("lsu_c6_we", 64'(bus.rd_we), 64'd0);

    // Contention: ALU in cycles 2-4, LSU entries pushed in cycles 2 and 3
    next_cyc();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
    mid(); chk("con_c0_ready", 64'(bus.issue_ready), 64'd1);
    next_cyc();
    bus.issue_valid = 1'b1; bus.issue_rd = 5'd13;
    mid(); chk("con_c1_ready", 64'(bus.issue_ready), 64'd1);
    next_cyc();
    bus.issue_rd = 5'd14;
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hA0;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd9; bus.lsu_data = 32'h99;
    mid(); chk("con_c2_full_issue", 64'(bus.issue_ready), 64'd0);
    next_cyc();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd11; bus.alu_data = 32'hA1;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd13; bus.lsu_data = 32'h1313;
    mid(); chk_wr("con_c3", 5'd10, 32'hA0);
    chk("con_c3_lready", 64'(bus.lsu_ready), 64'd1);
    next_cyc();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hA2;
    mid(); chk_wr("con_c4", 5'd11, 32'hA1);
    chk("con_c4_lready_full", 64'(bus.lsu_ready), 64'd0);
    next_cyc(); mid(); chk_wr("con_c5", 5'd12, 32'hA2);
    bus.rs1 = 5'd9;
    next_cyc(); mid(); chk_wr("con_c6", 5'd9, 32'h99);
    chk("con_c6_busy", 64'(bus.rs1_busy), 64'd1);
    chk("con_c6_lready", 64'(bus.lsu_ready), 64'd1);
    next_cyc(); mid(); chk_wr("con_c7", 5'd13, 32'h1313);
    chk("con_c7_busy", 64'(bus.rs1_busy), 64'd0);
    next_cyc(); mid();
    chk("con_c8_we", 64'(bus.rd_we), 64'd0);
    chk("con_c8_ready", 64'(bus.issue_ready), 64'd1);

    // Limits with DEPTH = 2
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd1;
    mid(); chk("lim_rd1", 64'(bus.issue_ready), 64'd1);
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd2;
    mid(); chk("lim_rd2", 64'(bus.issue_ready), 64'd1);
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd3;
    mid(); chk("lim_rd3_full", 64'(bus.issue_ready), 64'd0);
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd1;
    mid(); chk("lim_waw_rd1", 64'(bus.issue_ready), 64'd0);
    next_cyc(); bus.issue_rd = 5'd3;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd1; bus.lsu_data = 32'h11;
    next_cyc(); mid(); chk("lim_pop_ready", 64'(bus.issue_ready), 64'd0);
    next_cyc(); mid(); chk_wr("lim_wb1", 5'd1, 32'h11);
    chk("lim_wb_ready", 64'(bus.issue_ready), 64'd0);
    next_cyc();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h22;
    mid(); chk("lim_after_ready", 64'(bus.issue_ready), 64'd1);
    next_cyc();
    next_cyc(); mid(); chk_wr("lim_wb2", 5'd2, 32'h22);
    bus.rs1 = 5'd2;
    next_cyc(); mid();
    chk("lim_rd2_free", 64'(bus.rs1_busy), 64'd0);

    // Same-index set and clear on rd 4 with one other reservation outstanding
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd6;
    next_cyc();
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'h44;
    next_cyc();
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd4;
    mid(); chk_wr("same_wb4", 5'd4, 32'h44);
    chk("same_ready4", 64'(bus.issue_ready), 64'd1);
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd8; bus.rs1 = 5'd4;
    mid(); chk("same_busy4", 64'(bus.rs1_busy), 64'd1);
    chk("same_ready8", 64'(bus.issue_ready), 64'd1);
    next_cyc(); bus.issue_valid = 1'b1; bus.issue_rd = 5'd11;
    mid(); chk("same_full11", 64'(bus.issue_ready), 64'd0);

    // Reset mid-traffic
    next_cyc();
    bus.alu_valid = 1'b1; bus.alu_rd = 5'd21; bus.alu_data = 32'h21;
    bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd6; bus.lsu_data = 32'h66;
    bus.rs1 = 5'd6; bus.issue_rd = 5'd8;
    next_cyc(); mid(); chk_wr("pre_rst", 5'd21, 32'h21);
    chk("pre_rst_busy", 64'(bus.rs1_busy), 64'd1);
    next_cyc();
    rst_n = 1'b0;
    #1;
    chk("mid_rst_we", 64'(bus.rd_we), 64'd0);
    chk("mid_rst_rd", 64'(bus.rd), 64'd0);
    chk("mid_rst_data", 64'(bus.rd_data), 64'd0);
    chk("mid_rst_ready", 64'(bus.issue_ready), 64'd1);
    chk("mid_rst_busy", 64'(bus.rs1_busy), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    next_cyc(); mid(); chk("post_rst_we0", 64'(bus.rd_we), 64'd0);
    next_cyc(); mid(); chk("post_rst_we1", 64'(bus.rd_we), 64'd0);
    chk("post_rst_busy", 64'(bus.rs1_busy), 64'd0);
    chk("post_rst_ready", 64'(bus.issue_ready), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
